seven_segment_capture: RTL

- Receive-side counterpart of the hex-to-segment encoder.
- Samples a multiplexed, active-low seven-segment bus (segment lines plus per-digit anode enables) and waits until each digit's pattern is stable.
- Decodes the stable pattern back to a 4-bit hex value and holds one value per digit.
- Used as an on-chip display monitor and as a self-check path for the display driver.

---
 rtl/seven_segment_capture.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_capture.sv
// Captures a multiplexed active-low seven-segment bus and decodes each digit back to hex once stable.
// Optional decimal-point capture is enabled by defining SEVSEG_CAPTURE_DP_EN.
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
`ifdef SEVSEG_CAPTURE_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_err,
  output logic                    update,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] update_idx
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEVSEG_CAPTURE_DP_EN
  localparam int SMP_W = NUM_DIGITS + 8;
`else
  localparam int SMP_W = NUM_DIGITS + 7;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic [SMP_W-1:0]        cur, ref_q, ref_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sel_valid, commit, restart;
  logic [IDX_W-1:0]        sel_idx;
  logic [4:0]              dec;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   vld_q, vld_d, err_q, err_d;
  logic                    update_q;
  logic [IDX_W-1:0]        update_idx_q;

`ifdef SEVSEG_CAPTURE_DP_EN
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   dpo_q, dpo_d;
  assign cur = {an_q, seg_q, dp_q};
`else
  assign cur = {an_q, seg_q};
`endif

  // Returns {legal, nibble}; only the sixteen encoder patterns are legal.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    sel_valid = ($countones(~an_q) == 1);
    sel_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    commit  = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_valid) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
          ref_d   = cur;
        end
      end
      SETTLE: begin
        if (cur == ref_q) begin
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE >= CNT_MAX) begin
            state_d = COMMIT;
            commit  = 1'b1;
          end
        end else begin
          restart = 1'b1;
        end
      end
      default: begin
        if (cur == ref_q) state_d = HOLD;
        else              restart = 1'b1;
      end
    endcase
    // A new valid selection restarts the window immediately rather than via IDLE.
    if (restart) begin
      if (sel_valid) begin
        state_d = SETTLE;
        cnt_d   = CNT_ONE;
        ref_d   = cur;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    hex_d = hex_q;
    vld_d = vld_q;
    err_d = err_q;
    dec   = decode(seg_q);
`ifdef SEVSEG_CAPTURE_DP_EN
    dpo_d = dpo_q;
`endif
    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IDX_W'(i) == sel_idx) begin
          if (dec[4]) begin
            hex_d[4*i +: 4] = dec[3:0];
            vld_d[i]        = 1'b1;
          end else if (seg_q == 7'h7F) begin
            vld_d[i] = 1'b0;
          end else begin
            err_d[i] = 1'b1;
          end
`ifdef SEVSEG_CAPTURE_DP_EN
          dpo_d[i] = ~dp_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ref_q        <= '1;
      an_q         <= '1;
      seg_q        <= '1;
      hex_q        <= '0;
      vld_q        <= '0;
      err_q        <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
`ifdef SEVSEG_CAPTURE_DP_EN
      dp_q         <= 1'b1;
      dpo_q        <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      an_q     <= an_in;
      seg_q    <= seg_in;
      hex_q    <= hex_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      update_q <= commit;
      if (commit) update_idx_q <= sel_idx;
`ifdef SEVSEG_CAPTURE_DP_EN
      dp_q     <= dp_in;
      dpo_q    <= dpo_d;
`endif
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = vld_q;
  assign pattern_err = err_q;
  assign update      = update_q;
  assign update_idx  = update_idx_q;
`ifdef SEVSEG_CAPTURE_DP_EN
  assign dp_out      = dpo_q;
`endif

endmodule
